// File: rtl/inst_buffer_pkg.sv
// Shared fetch-side types for the instruction buffer: the prefetch packet
// handed from prefetch_queue to decode, and the default buffer depth.
package inst_buffer_pkg;

  localparam int IB_DEPTH = 8;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
  } PREFETCH_PACKET;

endpackage

// File: rtl/inst_buffer.sv
// In-order instruction FIFO between prefetch_queue and decode.
// fetch_en is a pure function of registered occupancy, so fetch stalls
// without any combinational path from deq. A flush (taken branch) empties
// the buffer in one edge so no wrong-path instruction reaches decode.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = IB_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  PREFETCH_PACKET   packet_in,
  input  logic             deq,
  output PREFETCH_PACKET   packet_out,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             fetch_en
);

  localparam int PTR_W = $clog2(DEPTH);

  PREFETCH_PACKET   mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_next;
  logic [PTR_W-1:0] tail_next;
  logic [CNT_W-1:0] count_next;
  logic             enq_fire;
  logic             deq_fire;
  logic             mem_we;

  // Status comes from the occupancy register only; a full buffer refuses
  // packet_in even when decode dequeues in the same cycle.
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign fetch_en = !full;

  // Next-state: flush wins over enqueue and dequeue; pointers wrap mod DEPTH.
  always_comb begin
    enq_fire   = packet_in.valid && !full;
    deq_fire   = deq && !empty;
    head_next  = head;
    tail_next  = tail;
    count_next = count;
    mem_we     = 1'b0;
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (enq_fire) begin
        mem_we    = 1'b1;
        tail_next = tail + PTR_W'(1);
      end
      if (deq_fire) begin
        head_next = head + PTR_W'(1);
      end
      count_next = count + CNT_W'(enq_fire) - CNT_W'(deq_fire);
    end
  end

  // Head entry straight from storage, zeroed when empty so stale or
  // never-written slots are never exposed.
  always_comb begin
    packet_out = '0;
    if (!empty) begin
      packet_out       = mem[head];
      packet_out.valid = 1'b1;
    end
  end

  // Control state takes the synchronous active-low reset; the data array does not.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next;
    end
    if (reset && mem_we) begin
      mem[tail] <= packet_in;
    end
  end

endmodule
